moxie_core_pipe: RTL and testbench

- Three-stage Moxie integer front-end: fetch, decode and execute, with an internal read-after-write hazard stall.
- Fetches big-endian 16-bit Moxie opcodes, plus an optional 32-bit immediate, from a combinational instruction memory.
- Decodes a form-1 ALU subset and drives an external register file: combinational reads, writes at posedge, no bypass.
- Sits under the SoC top, beside the register file.

---
 rtl/moxie_pkg.sv | 40 ++++
 rtl/moxie_fetch_unit.sv | 95 +++++++++
 rtl/moxie_core_pipe.sv | 147 ++++++++++++++
 tb/tb_moxie_core_pipe.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/moxie_pkg.sv
// Shared definitions for the Moxie front-end: opcode bytes, execute operations
// and fetch FSM states.
package moxie_pkg;

    localparam logic [7:0] OPC_LDI  = 8'h01;
    localparam logic [7:0] OPC_MOV  = 8'h02;
    localparam logic [7:0] OPC_JSRA = 8'h03;
    localparam logic [7:0] OPC_ADD  = 8'h05;
    localparam logic [7:0] OPC_LDA  = 8'h08;
    localparam logic [7:0] OPC_STA  = 8'h09;
    localparam logic [7:0] OPC_JMPA = 8'h1a;
    localparam logic [7:0] OPC_AND  = 8'h26;
    localparam logic [7:0] OPC_LSHR = 8'h27;
    localparam logic [7:0] OPC_ASHL = 8'h28;
    localparam logic [7:0] OPC_SUB  = 8'h29;
    localparam logic [7:0] OPC_NEG  = 8'h2a;
    localparam logic [7:0] OPC_OR   = 8'h2b;
    localparam logic [7:0] OPC_NOT  = 8'h2c;
    localparam logic [7:0] OPC_ASHR = 8'h2d;
    localparam logic [7:0] OPC_XOR  = 8'h2e;
    localparam logic [7:0] OPC_MUL  = 8'h2f;

    typedef enum logic [3:0] {
        EX_NOP, EX_LDI, EX_MOV, EX_ADD, EX_SUB, EX_AND, EX_OR,
        EX_XOR, EX_MUL, EX_LSHR, EX_ASHL, EX_ASHR, EX_NEG, EX_NOT
    } exec_op_e;

    typedef enum logic [1:0] {
        FS_OPC,
        FS_IMM_HI,
        FS_IMM_LO
    } fetch_state_e;

    // Opcodes that are followed by a 32-bit immediate in the instruction stream.
    function automatic logic has_imm(input logic [7:0] op);
        return (op == OPC_LDI) || (op == OPC_JSRA) || (op == OPC_LDA) ||
               (op == OPC_STA) || (op == OPC_JMPA);
    endfunction

endpackage

// File: rtl/moxie_fetch_unit.sv
// Halfword fetch engine: walks the pc two bytes at a time and assembles an
// opcode plus optional 32-bit immediate into a single valid pulse.
module moxie_fetch_unit
    import moxie_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_1000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic [31:0] imem_data_i,
    output logic [31:0] imem_address_o,
    output logic        valid_o,
    output logic [15:0] opcode_o,
    output logic [31:0] operand_o
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [15:0]  opc_hold_q, opc_hold_d;
    logic [15:0]  imm_hi_q, imm_hi_d;
    logic         valid_q, valid_d;
    logic [15:0]  opcode_q, opcode_d;
    logic [31:0]  operand_q, operand_d;
    logic [15:0]  hword;

    // Big-endian: the halfword at byte offset 0 sits in the upper half.
    assign hword          = pc_q[1] ? imem_data_i[15:0] : imem_data_i[31:16];
    assign imem_address_o = {pc_q[31:2], 2'b00};

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        opc_hold_d = opc_hold_q;
        imm_hi_d   = imm_hi_q;
        valid_d    = 1'b0;
        opcode_d   = opcode_q;
        operand_d  = operand_q;
        if (stall_i) begin
            valid_d = valid_q;
        end else begin
            pc_d = pc_q + 32'd2;
            case (state_q)
                FS_OPC: begin
                    if (has_imm(hword[15:8])) begin
                        opc_hold_d = hword;
                        state_d    = FS_IMM_HI;
                    end else begin
                        valid_d  = 1'b1;
                        opcode_d = hword;
                    end
                end
                FS_IMM_HI: begin
                    imm_hi_d = hword;
                    state_d  = FS_IMM_LO;
                end
                FS_IMM_LO: begin
                    valid_d   = 1'b1;
                    opcode_d  = opc_hold_q;
                    operand_d = {imm_hi_q, hword};
                    state_d   = FS_OPC;
                end
                default: begin
                    pc_d    = pc_q;
                    state_d = FS_OPC;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= FS_OPC;
            pc_q       <= RESET_PC;
            opc_hold_q <= 16'h0;
            imm_hi_q   <= 16'h0;
            valid_q    <= 1'b0;
            opcode_q   <= 16'h0;
            operand_q  <= 32'h0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            opc_hold_q <= opc_hold_d;
            imm_hi_q   <= imm_hi_d;
            valid_q    <= valid_d;
            opcode_q   <= opcode_d;
            operand_q  <= operand_d;
        end
    end

    assign valid_o   = valid_q;
    assign opcode_o  = opcode_q;
    assign operand_o = operand_q;

endmodule

// File: rtl/moxie_core_pipe.sv
// Three-stage Moxie integer front-end (fetch, decode, execute) driving an
// external register file, with a one-cycle read-after-write stall.
module moxie_core_pipe
    import moxie_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_1000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic [31:0] imem_address_o,
    input  logic [31:0] imem_data_i,
    output logic [3:0]  rf_read_index_a_o,
    output logic [3:0]  rf_read_index_b_o,
    output logic        rf_read_enable_o,
    input  logic [31:0] rf_value_a_i,
    input  logic [31:0] rf_value_b_i,
    output logic        rf_write_enable_o,
    output logic [3:0]  rf_write_index_o,
    output logic [31:0] rf_write_data_o,
    output logic        stall_o
);

    logic        f_valid;
    logic [15:0] f_opcode;
    logic [31:0] f_operand;

    moxie_fetch_unit #(.RESET_PC(RESET_PC)) u_fetch (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .stall_i        (stall_o),
        .imem_data_i    (imem_data_i),
        .imem_address_o (imem_address_o),
        .valid_o        (f_valid),
        .opcode_o       (f_opcode),
        .operand_o      (f_operand)
    );

    // Decode stage
    exec_op_e    dec_op_q, dec_op_d;
    logic [3:0]  idx_a_q, idx_a_d, idx_b_q, idx_b_d;
    logic        rd_a_en_q, rd_a_en_d, rd_b_en_q, rd_b_en_d;
    logic [31:0] dec_imm_q, dec_imm_d;

    always_comb begin
        dec_op_d  = EX_NOP;
        rd_a_en_d = 1'b0;
        rd_b_en_d = 1'b0;
        idx_a_d   = f_opcode[7:4];
        idx_b_d   = f_opcode[3:0];
        dec_imm_d = f_operand;
        if (f_valid) begin
            case (f_opcode[15:8])
                OPC_LDI:  dec_op_d = EX_LDI;
                OPC_MOV:  begin dec_op_d = EX_MOV;  rd_b_en_d = 1'b1; end
                OPC_NEG:  begin dec_op_d = EX_NEG;  rd_b_en_d = 1'b1; end
                OPC_NOT:  begin dec_op_d = EX_NOT;  rd_b_en_d = 1'b1; end
                OPC_ADD:  begin dec_op_d = EX_ADD;  rd_a_en_d = 1'b1; rd_b_en_d = 1'b1; end
                OPC_SUB:  begin dec_op_d = EX_SUB;  rd_a_en_d = 1'b1; rd_b_en_d = 1'b1; end
                OPC_AND:  begin dec_op_d = EX_AND;  rd_a_en_d = 1'b1; rd_b_en_d = 1'b1; end
                OPC_OR:   begin dec_op_d = EX_OR;   rd_a_en_d = 1'b1; rd_b_en_d = 1'b1; end
                OPC_XOR:  begin dec_op_d = EX_XOR;  rd_a_en_d = 1'b1; rd_b_en_d = 1'b1; end
                OPC_MUL:  begin dec_op_d = EX_MUL;  rd_a_en_d = 1'b1; rd_b_en_d = 1'b1; end
                OPC_LSHR: begin dec_op_d = EX_LSHR; rd_a_en_d = 1'b1; rd_b_en_d = 1'b1; end
                OPC_ASHL: begin dec_op_d = EX_ASHL; rd_a_en_d = 1'b1; rd_b_en_d = 1'b1; end
                OPC_ASHR: begin dec_op_d = EX_ASHR; rd_a_en_d = 1'b1; rd_b_en_d = 1'b1; end
                default:  dec_op_d = EX_NOP;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            dec_op_q  <= EX_NOP;
            idx_a_q   <= 4'h0;
            idx_b_q   <= 4'h0;
            rd_a_en_q <= 1'b0;
            rd_b_en_q <= 1'b0;
            dec_imm_q <= 32'h0;
        end else if (!stall_o) begin
            dec_op_q  <= dec_op_d;
            idx_a_q   <= idx_a_d;
            idx_b_q   <= idx_b_d;
            rd_a_en_q <= rd_a_en_d;
            rd_b_en_q <= rd_b_en_d;
            dec_imm_q <= dec_imm_d;
        end
    end

    assign rf_read_index_a_o = idx_a_q;
    assign rf_read_index_b_o = idx_b_q;
    assign rf_read_enable_o  = rd_a_en_q | rd_b_en_q;

    // Execute stage
    logic               wr_en_q, wr_en_d;
    logic [3:0]         wr_idx_q, wr_idx_d;
    logic [31:0]        wr_data_q, wr_data_d;
    logic signed [31:0] a_signed;
    logic [4:0]         shamt;

    assign a_signed = rf_value_a_i;
    assign shamt    = rf_value_b_i[4:0];

    always_comb begin
        wr_en_d  = (dec_op_q != EX_NOP);
        wr_idx_d = idx_a_q;
        case (dec_op_q)
            EX_LDI:  wr_data_d = dec_imm_q;
            EX_MOV:  wr_data_d = rf_value_b_i;
            EX_ADD:  wr_data_d = rf_value_a_i + rf_value_b_i;
            EX_SUB:  wr_data_d = rf_value_a_i - rf_value_b_i;
            EX_AND:  wr_data_d = rf_value_a_i & rf_value_b_i;
            EX_OR:   wr_data_d = rf_value_a_i | rf_value_b_i;
            EX_XOR:  wr_data_d = rf_value_a_i ^ rf_value_b_i;
            EX_MUL:  wr_data_d = rf_value_a_i * rf_value_b_i;
            EX_LSHR: wr_data_d = rf_value_a_i >> shamt;
            EX_ASHL: wr_data_d = rf_value_a_i << shamt;
            EX_ASHR: wr_data_d = a_signed >>> shamt;
            EX_NEG:  wr_data_d = 32'h0 - rf_value_b_i;
            EX_NOT:  wr_data_d = ~rf_value_b_i;
            default: wr_data_d = wr_data_q;
        endcase
    end

    // A stalled edge retires nothing: the pending write lands now, so the
    // held decode re-reads a fresh register file on the following cycle.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_en_q   <= 1'b0;
            wr_idx_q  <= 4'h0;
            wr_data_q <= 32'h0;
        end else if (stall_o) begin
            wr_en_q   <= 1'b0;
        end else begin
            wr_en_q   <= wr_en_d;
            wr_idx_q  <= wr_idx_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign rf_write_enable_o = wr_en_q;
    assign rf_write_index_o  = wr_idx_q;
    assign rf_write_data_o   = wr_data_q;

    assign stall_o = (rd_a_en_q & wr_en_q & (idx_a_q == wr_idx_q)) |
                     (rd_b_en_q & wr_en_q & (idx_b_q == wr_idx_q));

endmodule

// File: tb/tb_moxie_core_pipe.sv
// Directed bench for moxie_core_pipe with instruction memory and register file models.
module tb_moxie_core_pipe;
    import moxie_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic [31:0] imem_address_o;
    logic [31:0] imem_data_i;
    logic [3:0]  rf_read_index_a_o, rf_read_index_b_o;
    logic        rf_read_enable_o;
    logic [31:0] rf_value_a_i, rf_value_b_i;
    logic        rf_write_enable_o;
    logic [3:0]  rf_write_index_o;
    logic [31:0] rf_write_data_o;
    logic        stall_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_i = ~clk_i;

    moxie_core_pipe #(.RESET_PC(32'h0000_1000)) dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .imem_address_o    (imem_address_o),
        .imem_data_i       (imem_data_i),
        .rf_read_index_a_o (rf_read_index_a_o),
        .rf_read_index_b_o (rf_read_index_b_o),
        .rf_read_enable_o  (rf_read_enable_o),
        .rf_value_a_i      (rf_value_a_i),
        .rf_value_b_i      (rf_value_b_i),
        .rf_write_enable_o (rf_write_enable_o),
        .rf_write_index_o  (rf_write_index_o),
        .rf_write_data_o   (rf_write_data_o),
        .stall_o           (stall_o)
    );

    // Instruction memory: 1 KiB window at 0x1000, NOP words (0x0f00) elsewhere.
    logic [31:0] mem [0:255];
    logic [31:0] off;
    always_comb begin
        off = imem_address_o - 32'h0000_1000;
        if (off < 32'h400) imem_data_i = mem[off[9:2]];
        else               imem_data_i = 32'h0f00_0f00;
    end

    // Register file model: combinational reads, write at posedge, no bypass.
    logic [31:0] rf [0:15];
    assign rf_value_a_i = rf[rf_read_index_a_o];
    assign rf_value_b_i = rf[rf_read_index_b_o];
    always @(posedge clk_i) if (rf_write_enable_o) rf[rf_write_index_o] <= rf_write_data_o;

    // Log of every committed write, sampled mid-cycle.
    logic [3:0]  log_idx  [0:255];
    logic [31:0] log_data [0:255];
    int nwr = 0;
    always @(negedge clk_i) begin
        if (rst_i && rf_write_enable_o) begin
            log_idx[nwr[7:0]]  <= rf_write_index_o;
            log_data[nwr[7:0]] <= rf_write_data_o;
            nwr <= nwr + 1;
        end
    end

    logic [15:0] prog [$];

    task automatic emit(input logic [15:0] h);
        prog.push_back(h);
    endtask

    task automatic emit_ldi(input logic [3:0] r, input logic [31:0] v);
        emit({8'h01, r, 4'h0});
        emit(v[31:16]);
        emit(v[15:0]);
    endtask

    task automatic load_prog;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0f00_0f00;
        for (int i = 0; i < prog.size(); i++) begin
            if (i[0] == 1'b0) mem[i[8:1]][31:16] = prog[i];
            else              mem[i[8:1]][15:0]  = prog[i];
        end
        prog.delete();
    endtask

    task automatic hold_reset;
        rst_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
    endtask

    task automatic wait_writes(input int target, input int budget);
        for (int c = 0; c < budget && nwr < target; c++) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic test_reset;
        emit_ldi(4'd1, 32'd5);
        emit(16'h0f00);
        load_prog();
        hold_reset();
        n_checks++;
        if (imem_address_o !== 32'h0000_1000) begin
            n_fail++; $display("FAIL reset_addr: got %h expected %h", imem_address_o, 32'h1000);
        end
        n_checks++;
        if (rf_write_enable_o !== 1'b0 || stall_o !== 1'b0 || rf_read_enable_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_ctrl: got we=%b stall=%b re=%b expected 0 0 0",
                               rf_write_enable_o, stall_o, rf_read_enable_o);
        end
        n_checks++;
        if (rf_write_index_o !== 4'h0 || rf_write_data_o !== 32'h0) begin
            n_fail++; $display("FAIL reset_wdata: got idx=%h data=%h expected 0 0",
                               rf_write_index_o, rf_write_data_o);
        end
        rst_i = 1'b1;
        #1;
        n_checks++;
        if (imem_address_o !== 32'h0000_1000) begin
            n_fail++; $display("FAIL first_fetch_addr: got %h expected %h", imem_address_o, 32'h1000);
        end
    endtask

    task automatic test_ldi;
        logic [31:0] exp_addr [1:4];
        exp_addr = '{32'h1000, 32'h1004, 32'h1004, 32'h1008};
        for (int cyc = 1; cyc <= 8; cyc++) begin
            @(posedge clk_i);
            #1;
            n_checks++;
            if (rf_write_enable_o !== (cyc == 5)) begin
                n_fail++; $display("FAIL ldi_we_cycle%0d: got %b expected %b", cyc, rf_write_enable_o, (cyc == 5));
            end
            if (cyc == 5) begin
                n_checks++;
                if (rf_write_index_o !== 4'd1 || rf_write_data_o !== 32'd5) begin
                    n_fail++; $display("FAIL ldi_result: got idx=%0d data=%h expected idx=1 data=00000005",
                                       rf_write_index_o, rf_write_data_o);
                end
            end
            if (cyc <= 4) begin
                n_checks++;
                if (imem_address_o !== exp_addr[cyc]) begin
                    n_fail++; $display("FAIL ldi_addr_cycle%0d: got %h expected %h", cyc, imem_address_o, exp_addr[cyc]);
                end
            end
        end
    endtask

    task automatic test_add_hazard;
        int base;
        logic [3:0]  ei [0:2];
        logic [31:0] ed [0:2];
        ei = '{4'd1, 4'd2, 4'd1};
        ed = '{32'd5, 32'd7, 32'd12};
        emit_ldi(4'd1, 32'd5);
        emit_ldi(4'd2, 32'd7);
        emit(16'h0512);
        load_prog();
        hold_reset();
        base = nwr;
        rst_i = 1'b1;
        for (int cyc = 1; cyc <= 14; cyc++) begin
            @(posedge clk_i);
            #1;
            n_checks++;
            if (stall_o !== (cyc == 8)) begin
                n_fail++; $display("FAIL hazard_stall_cycle%0d: got %b expected %b", cyc, stall_o, (cyc == 8));
            end
        end
        n_checks++;
        if (nwr - base !== 3) begin
            n_fail++; $display("FAIL hazard_write_count: got %0d expected 3", nwr - base);
        end else begin
            for (int k = 0; k < 3; k++) begin
                n_checks++;
                if (log_idx[base + k] !== ei[k] || log_data[base + k] !== ed[k]) begin
                    n_fail++; $display("FAIL hazard_write%0d: got idx=%0d data=%h expected idx=%0d data=%h",
                                       k, log_idx[base + k], log_data[base + k], ei[k], ed[k]);
                end
            end
        end
    endtask

    task automatic test_alu_sweep;
        int base;
        logic [3:0]  ei [0:17];
        logic [31:0] ed [0:17];
        ei = '{4'd2, 4'd3, 4'd3, 4'd4, 4'd4, 4'd5, 4'd5, 4'd6, 4'd7,
               4'd8, 4'd9, 4'd8, 4'd9, 4'd9, 4'd9, 4'd9, 4'd10, 4'd10};
        ed = '{32'h4, 32'h8000_0000, 32'hF800_0000, 32'h8000_0000, 32'h0800_0000,
               32'h8000_0000, 32'h7FFF_FFFC, 32'hFFFF_FFFB, 32'hFFFF_FFFC,
               32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFE, 32'h20, 32'h24, 32'h4,
               32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'h2};
        emit_ldi(4'd2, 32'd4);
        emit_ldi(4'd3, 32'h8000_0000); emit(16'h2d32);
        emit_ldi(4'd4, 32'h8000_0000); emit(16'h2742);
        emit_ldi(4'd5, 32'h8000_0000); emit(16'h2952);
        emit(16'h2c62);
        emit(16'h2a72);
        emit_ldi(4'd8, 32'hFFFF_FFFF); emit_ldi(4'd9, 32'd2); emit(16'h2f89);
        emit(16'h2892); emit(16'h2e92); emit(16'h2692); emit(16'h2b98);
        emit(16'h02a9); emit(16'h05a2);
        load_prog();
        hold_reset();
        base = nwr;
        rst_i = 1'b1;
        wait_writes(base + 18, 300);
        repeat (6) @(posedge clk_i);
        #1;
        n_checks++;
        if (nwr - base !== 18) begin
            n_fail++; $display("FAIL alu_write_count: got %0d expected 18", nwr - base);
        end else begin
            for (int k = 0; k < 18; k++) begin
                n_checks++;
                if (log_idx[base + k] !== ei[k] || log_data[base + k] !== ed[k]) begin
                    n_fail++; $display("FAIL alu_write%0d: got idx=%0d data=%h expected idx=%0d data=%h",
                                       k, log_idx[base + k], log_data[base + k], ei[k], ed[k]);
                end
            end
        end
    endtask

    task automatic test_long_nop;
        int base;
        emit(16'h9000);
        emit(16'h1a00);
        emit(16'h0510);
        emit(16'h0510);
        load_prog();
        hold_reset();
        base = nwr;
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        n_checks++;
        if (dut.u_fetch.pc_q !== 32'h1002) begin
            n_fail++; $display("FAIL nop16_pc: got %h expected %h", dut.u_fetch.pc_q, 32'h1002);
        end
        @(posedge clk_i); #1;
        n_checks++;
        if (dut.u_fetch.state_q !== FS_IMM_HI) begin
            n_fail++; $display("FAIL nop48_state: got %0d expected %0d", dut.u_fetch.state_q, FS_IMM_HI);
        end
        repeat (2) @(posedge clk_i);
        #1;
        n_checks++;
        if (dut.u_fetch.pc_q !== 32'h1008 || dut.u_fetch.state_q !== FS_OPC) begin
            n_fail++; $display("FAIL nop48_pc: got pc=%h state=%0d expected pc=%h state=%0d",
                               dut.u_fetch.pc_q, dut.u_fetch.state_q, 32'h1008, FS_OPC);
        end
        repeat (10) @(posedge clk_i);
        #1;
        n_checks++;
        if (nwr - base !== 0) begin
            n_fail++; $display("FAIL nop_writes: got %0d expected 0", nwr - base);
        end
    endtask

    task automatic test_reset_mid_ldi;
        int base;
        emit_ldi(4'd5, 32'hDEAD_BEEF);
        load_prog();
        hold_reset();
        base = nwr;
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        n_checks++;
        if (dut.u_fetch.state_q !== FS_IMM_HI) begin
            n_fail++; $display("FAIL midldi_state_before: got %0d expected %0d", dut.u_fetch.state_q, FS_IMM_HI);
        end
        rst_i = 1'b0;
        #1;
        n_checks++;
        if (dut.u_fetch.pc_q !== 32'h1000 || dut.u_fetch.state_q !== FS_OPC || imem_address_o !== 32'h1000) begin
            n_fail++; $display("FAIL midldi_async_reset: got pc=%h state=%0d addr=%h expected pc=00001000 state=%0d",
                               dut.u_fetch.pc_q, dut.u_fetch.state_q, imem_address_o, FS_OPC);
        end
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        repeat (12) @(posedge clk_i);
        #1;
        n_checks++;
        if (nwr - base !== 1) begin
            n_fail++; $display("FAIL midldi_write_count: got %0d expected 1", nwr - base);
        end else begin
            n_checks++;
            if (log_idx[base] !== 4'd5 || log_data[base] !== 32'hDEAD_BEEF) begin
                n_fail++; $display("FAIL midldi_write: got idx=%0d data=%h expected idx=5 data=deadbeef",
                                   log_idx[base], log_data[base]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_ldi();
        test_add_hazard();
        test_alu_sweep();
        test_long_nop();
        test_reset_mid_ldi();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

endmodule
